// File: rtl/handshake_serializer_if.sv
// Valid-ready bundle for handshake_serializer: wide vector in, element beats out.
// The slave modport is the serializer's view; master is the view of whatever drives it.
interface handshake_serializer_if #(
  parameter int ELEM_W    = 16,
  parameter int NUM_ELEMS = 8
);
  logic                          vec_vld_in;
  logic                          vec_rdy_out;
  logic [NUM_ELEMS*ELEM_W-1:0]   vec_in;
  logic                          vld_out;
  logic                          rdy_in;
  logic [ELEM_W-1:0]             data_out;
  logic                          last_out;

  modport master (
    output vec_vld_in, vec_in, rdy_in,
    input  vec_rdy_out, vld_out, data_out, last_out
  );

  modport slave (
    input  vec_vld_in, vec_in, rdy_in,
    output vec_rdy_out, vld_out, data_out, last_out
  );
endinterface

// File: rtl/handshake_serializer.sv
// Accepts one NUM_ELEMS-element vector per upstream handshake and streams it out
// element by element, refilling on the last beat so back-to-back vectors have no bubble.
module handshake_serializer #(
  parameter int ELEM_W    = 16,
  parameter int NUM_ELEMS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  handshake_serializer_if.slave bus
);
  localparam int CNT_W = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ELEMS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                      state, state_nxt;
  logic [CNT_W-1:0]            cnt, cnt_nxt;
  logic [NUM_ELEMS*ELEM_W-1:0] vec_reg, vec_nxt;
  logic                        busy;
  logic                        last;
  logic                        take_vec;

  assign busy     = (state == SEND);
  assign last     = busy && (cnt == LAST_IDX);
  // A new vector may enter while idle or on the very cycle the final beat is consumed.
  assign take_vec = bus.vec_vld_in && (!busy || (bus.rdy_in && last));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      vec_reg <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      vec_reg <= vec_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    vec_nxt   = vec_reg;
    if (take_vec) begin
      state_nxt = SEND;
      cnt_nxt   = '0;
      vec_nxt   = bus.vec_in;
    end else if (busy && bus.rdy_in) begin
      if (last) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    bus.vld_out     = busy;
    bus.last_out    = last;
    bus.vec_rdy_out = !busy || (bus.rdy_in && last);
    bus.data_out    = '0;
    for (int unsigned i = 0; i < NUM_ELEMS; i++) begin
      if (cnt == CNT_W'(i)) bus.data_out = vec_reg[i*ELEM_W +: ELEM_W];
    end
  end
endmodule

// File: tb/tb_handshake_serializer.sv
// Bench for handshake_serializer: directed vector tables on 4- and 1-element
// instances, then randomized valid/ready traffic on a 5-element instance against a queue model.
module tb_handshake_serializer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  handshake_serializer_if #(.ELEM_W(16), .NUM_ELEMS(4)) if4 ();
  handshake_serializer_if #(.ELEM_W(8),  .NUM_ELEMS(1)) if1 ();
  handshake_serializer_if #(.ELEM_W(16), .NUM_ELEMS(5)) if5 ();

  handshake_serializer #(.ELEM_W(16), .NUM_ELEMS(4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));
  handshake_serializer #(.ELEM_W(8),  .NUM_ELEMS(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  handshake_serializer #(.ELEM_W(16), .NUM_ELEMS(5)) u5 (.clk(clk), .rst(rst), .bus(if5.slave));

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int unsigned dut;
    logic        rs;
    logic        vvld;
    logic [63:0] vec;
    logic        rdy;
    logic        evld;
    logic        elast;
    logic        evrdy;
    logic [15:0] edata;
  } row_t;

  row_t tbl[$];

  task automatic add(input int unsigned d, input logic rs, input logic vv, input logic [63:0] v,
                     input logic rd, input logic ev, input logic el, input logic er,
                     input logic [15:0] ed);
    row_t r;
    r.dut = d; r.rs = rs; r.vvld = vv; r.vec = v; r.rdy = rd;
    r.evld = ev; r.elast = el; r.evrdy = er; r.edata = ed;
    tbl.push_back(r);
  endtask

  // Random-phase model: elements accepted but not yet delivered, oldest first.
  logic [15:0] q[$];
  int unsigned acc = 0, lasts = 0, pops = 0;

  task automatic rand_cycle();
    logic exp_vrdy;
    exp_vrdy = (q.size() == 0) || (if5.rdy_in && q.size() == 1);
    chk("r_vld", 64'(if5.vld_out), 64'(q.size() != 0));
    chk("r_vrdy", 64'(if5.vec_rdy_out), 64'(exp_vrdy));
    if (if5.vld_out && q.size() != 0) begin
      chk("r_data", 64'(if5.data_out), 64'(q[0]));
      chk("r_last", 64'(if5.last_out), 64'(q.size() == 1));
    end
    if (if5.vld_out && if5.rdy_in) begin
      if (q.size() != 0) void'(q.pop_front());
      pops++;
      if (if5.last_out) lasts++;
    end
    if (if5.vec_vld_in && if5.vec_rdy_out) begin
      for (int unsigned i = 0; i < 5; i++) q.push_back(if5.vec_in[i*16 +: 16]);
      acc++;
    end
  endtask

  localparam logic [63:0] A = 64'h0004_0003_0002_0001;
  localparam logic [63:0] B = 64'h0008_0007_0006_0005;

  initial begin
    row_t r;
    logic [79:0] v;
    logic held;
    int unsigned cyc;

    // dut rst vvld vec rdy | vld last vrdy data
    add(0,0,1,A,1, 0,0,1,16'h0);   // reset state, accept A
    add(0,0,0,0,1, 1,0,0,16'h1);
    add(0,0,0,0,1, 1,0,0,16'h2);
    add(0,0,0,0,1, 1,0,0,16'h3);
    add(0,0,0,0,1, 1,1,1,16'h4);
    add(0,0,0,0,1, 0,0,1,16'h1);
    add(0,0,1,A,1, 0,0,1,16'h1);   // back-to-back A then B
    add(0,0,1,B,1, 1,0,0,16'h1);
    add(0,0,1,B,1, 1,0,0,16'h2);
    add(0,0,1,B,1, 1,0,0,16'h3);
    add(0,0,1,B,1, 1,1,1,16'h4);
    add(0,0,0,0,1, 1,0,0,16'h5);
    add(0,0,0,0,1, 1,0,0,16'h6);
    add(0,0,0,0,1, 1,0,0,16'h7);
    add(0,0,0,0,1, 1,1,1,16'h8);
    add(0,0,0,0,1, 0,0,1,16'h5);
    add(0,0,1,A,1, 0,0,1,16'h5);   // backpressure 1,0,0,1,0,1,1
    add(0,0,0,0,1, 1,0,0,16'h1);
    add(0,0,0,0,0, 1,0,0,16'h2);
    add(0,0,0,0,0, 1,0,0,16'h2);
    add(0,0,0,0,1, 1,0,0,16'h2);
    add(0,0,0,0,0, 1,0,0,16'h3);
    add(0,0,0,0,1, 1,0,0,16'h3);
    add(0,0,0,0,1, 1,1,1,16'h4);
    add(0,0,0,0,1, 0,0,1,16'h1);
    add(0,0,1,A,1, 0,0,1,16'h1);   // reset mid-vector
    add(0,0,0,0,1, 1,0,0,16'h1);
    add(0,1,0,0,1, 1,0,0,16'h2);
    add(0,0,1,B,1, 0,0,1,16'h0);
    add(0,0,0,0,1, 1,0,0,16'h5);
    add(0,0,0,0,1, 1,0,0,16'h6);
    add(0,0,0,0,1, 1,0,0,16'h7);
    add(0,0,0,0,1, 1,1,1,16'h8);
    add(0,0,0,0,1, 0,0,1,16'h5);
    add(0,0,1,A,1, 0,0,1,16'h5);   // stall on last beat with next vector waiting
    add(0,0,0,0,1, 1,0,0,16'h1);
    add(0,0,0,0,1, 1,0,0,16'h2);
    add(0,0,0,0,1, 1,0,0,16'h3);
    add(0,0,1,B,0, 1,1,0,16'h4);
    add(0,0,1,B,1, 1,1,1,16'h4);
    add(0,0,0,0,1, 1,0,0,16'h5);
    add(0,0,0,0,1, 1,0,0,16'h6);
    add(0,0,0,0,1, 1,0,0,16'h7);
    add(0,0,0,0,1, 1,1,1,16'h8);
    add(0,0,0,0,1, 0,0,1,16'h5);
    add(1,0,1,64'h11,1, 0,0,1,16'h00);  // single-element pipeline
    add(1,0,1,64'h22,1, 1,1,1,16'h11);
    add(1,0,1,64'h33,1, 1,1,1,16'h22);
    add(1,0,0,64'h0,1,  1,1,1,16'h33);
    add(1,0,0,64'h0,1,  0,0,1,16'h33);
    add(1,0,1,64'h44,1, 0,0,1,16'h33);
    add(1,0,1,64'h55,0, 1,1,0,16'h44);
    add(1,0,1,64'h55,1, 1,1,1,16'h44);
    add(1,0,0,64'h0,1,  1,1,1,16'h55);
    add(1,0,0,64'h0,1,  0,0,1,16'h55);

    rst = 1'b1;
    if4.vec_vld_in = 1'b0; if4.vec_in = '0; if4.rdy_in = 1'b0;
    if1.vec_vld_in = 1'b0; if1.vec_in = '0; if1.rdy_in = 1'b0;
    if5.vec_vld_in = 1'b0; if5.vec_in = '0; if5.rdy_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      r = tbl[i];
      rst = r.rs;
      if4.vec_vld_in = (r.dut == 0) ? r.vvld : 1'b0;
      if4.vec_in     = r.vec;
      if4.rdy_in     = (r.dut == 0) ? r.rdy : 1'b0;
      if1.vec_vld_in = (r.dut == 1) ? r.vvld : 1'b0;
      if1.vec_in     = r.vec[7:0];
      if1.rdy_in     = (r.dut == 1) ? r.rdy : 1'b0;
      @(negedge clk);
      if (r.dut == 0) begin
        chk($sformatf("t%0d_vld", i),  64'(if4.vld_out),     64'(r.evld));
        chk($sformatf("t%0d_last", i), 64'(if4.last_out),    64'(r.elast));
        chk($sformatf("t%0d_vrdy", i), 64'(if4.vec_rdy_out), 64'(r.evrdy));
        chk($sformatf("t%0d_data", i), 64'(if4.data_out),    64'(r.edata));
      end else begin
        chk($sformatf("t%0d_vld", i),  64'(if1.vld_out),     64'(r.evld));
        chk($sformatf("t%0d_last", i), 64'(if1.last_out),    64'(r.elast));
        chk($sformatf("t%0d_vrdy", i), 64'(if1.vec_rdy_out), 64'(r.evrdy));
        chk($sformatf("t%0d_data", i), 64'(if1.data_out),    64'(r.edata[7:0]));
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    if4.vec_vld_in = 1'b0; if4.rdy_in = 1'b0;
    if1.vec_vld_in = 1'b0; if1.rdy_in = 1'b0;

    // Random stress: upstream holds an offered vector until it is taken.
    held = 1'b0;
    cyc  = 0;
    while (acc < 1000 && cyc < 40000) begin
      if (!held) begin
        if5.vec_vld_in = ($urandom_range(0, 3) != 0);
        for (int unsigned i = 0; i < 5; i++) v[i*16 +: 16] = 16'($urandom);
        if5.vec_in = v;
      end
      if5.rdy_in = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      held = if5.vec_vld_in && !if5.vec_rdy_out;
      rand_cycle();
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("r_accept_budget", 64'(acc >= 1000), 64'(1));

    if5.vec_vld_in = 1'b0;
    if5.rdy_in     = 1'b1;
    cyc = 0;
    while (q.size() != 0 && cyc < 20) begin
      @(negedge clk);
      rand_cycle();
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("r_drained", 64'(q.size()), 64'(0));
    chk("r_last_per_vec", 64'(lasts), 64'(acc));
    chk("r_beats", 64'(pops), 64'(acc * 5));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
